// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU operation sequencer: select codes,
// settle-counter width and the sequencer FSM state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Wide enough for the largest legal settle time (15 cycles).
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_settle_timer.sv
// Down-counter that times the ripple ALU settle window: load, decrement,
// and report done when the count is zero.
module alu_settle_timer
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             done
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one operation at a time to an external ripple ALU, waits for it to
// settle, then holds the captured result until downstream takes it.
// Optional zero flag port is enabled by defining ALU_SEQ_ZERO_FLAG_EN.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [2:0]  op_sel,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_sel,
    output logic        alu_less,
    input  logic [31:0] alu_result,
    input  logic        alu_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        cout
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    output logic        zero
`endif
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    seq_state_t  state_reg;
    seq_state_t  state_next;
    logic        accept;
    logic        capture;
    logic        retire;
    logic        settle_done;

    logic [31:0] alu_a_reg;
    logic [31:0] alu_b_reg;
    logic [2:0]  alu_sel_reg;
    logic [31:0] result_reg;
    logic        cout_reg;
    logic        out_valid_reg;

    alu_settle_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .load_value (SETTLE_LOAD),
        .dec        (state_reg == SETTLE),
        .done       (settle_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        capture    = 1'b0;
        retire     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_done) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    retire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands stay parked on the ALU inputs until the next acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_sel_reg   <= '0;
            result_reg    <= '0;
            cout_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                alu_a_reg   <= op_a;
                alu_b_reg   <= op_b;
                alu_sel_reg <= op_sel;
            end
            if (capture) begin
                result_reg    <= alu_result;
                cout_reg      <= alu_cout;
                out_valid_reg <= 1'b1;
            end else if (retire) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic zero_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_reg <= 1'b0;
        end else if (capture) begin
            zero_reg <= (alu_result == 32'h0);
        end
    end

    assign zero = zero_reg;
`endif

    assign in_ready  = (state_reg == IDLE) && rst_n;
    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_sel   = alu_sel_reg;
    assign alu_less  = (alu_sel_reg == ALU_SLT);
    assign result    = result_reg;
    assign cout      = cout_reg;
    assign out_valid = out_valid_reg;

endmodule
